// File: rtl/dsp_mac_sequencer.sv
// Sequencer that drives one DSP48A1 slice as an unsigned dot-product engine.
// Each accepted sample pair carries a (valid, first, last) tag down a 3-stage pipe that mirrors the slice registers.
module dsp_mac_sequencer #(
    parameter int LEN_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [LEN_W-1:0] CMD_LEN,
    input  logic             ABORT,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [17:0]      S_A,
    input  logic [17:0]      S_B,
    output logic             RES_VALID,
    input  logic             RES_READY,
    output logic [47:0]      RES_DATA,
    output logic             RES_OVF,
    output logic [17:0]      DSP_A,
    output logic [17:0]      DSP_B,
    output logic [17:0]      DSP_D,
    output logic [47:0]      DSP_C,
    output logic             DSP_CARRYIN,
    output logic [7:0]       DSP_OPMODE,
    output logic             DSP_CEA,
    output logic             DSP_CEB,
    output logic             DSP_CEM,
    output logic             DSP_CEP,
    output logic             DSP_CECARRYIN,
    output logic             DSP_CEOPMODE,
    output logic             DSP_RST,
    input  logic [47:0]      DSP_P,
    input  logic             DSP_CARRYOUT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [LEN_W-1:0] remain_q;
    logic             first_q;
    logic             t1_vld_q;
    logic             t1_first_q;
    logic             t1_last_q;
    logic             t2_vld_q;
    logic             t2_last_q;
    logic             t3_vld_q;
    logic             t3_last_q;
    logic             res_valid_q;
    logic [47:0]      res_data_q;
    logic             res_ovf_q;

    logic             abort_s;
    logic             cmd_fire_s;
    logic             s_fire_s;
    logic             last_pair_s;
    logic [7:0]       opmode_s;

    assign abort_s     = ABORT && (state_q != ST_IDLE);
    assign cmd_fire_s  = CMD_VALID && (state_q == ST_IDLE);
    assign s_fire_s    = S_VALID && S_READY && !abort_s;
    assign last_pair_s = (remain_q == LEN_ONE);

    // Job FSM, tag pipe and result registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            remain_q    <= LEN_ZERO;
            first_q     <= 1'b0;
            t1_vld_q    <= 1'b0;
            t1_first_q  <= 1'b0;
            t1_last_q   <= 1'b0;
            t2_vld_q    <= 1'b0;
            t2_last_q   <= 1'b0;
            t3_vld_q    <= 1'b0;
            t3_last_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 48'd0;
            res_ovf_q   <= 1'b0;
        end else if (abort_s) begin
            state_q     <= ST_IDLE;
            remain_q    <= LEN_ZERO;
            first_q     <= 1'b0;
            t1_vld_q    <= 1'b0;
            t1_first_q  <= 1'b0;
            t1_last_q   <= 1'b0;
            t2_vld_q    <= 1'b0;
            t2_last_q   <= 1'b0;
            t3_vld_q    <= 1'b0;
            t3_last_q   <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            t1_vld_q   <= s_fire_s;
            t1_first_q <= s_fire_s && first_q;
            t1_last_q  <= s_fire_s && last_pair_s;
            t2_vld_q   <= t1_vld_q;
            t2_last_q  <= t1_last_q;
            t3_vld_q   <= t2_vld_q;
            t3_last_q  <= t2_last_q;
            // Carry-out is only meaningful on cycles where a real pair reaches P.
            if (t3_vld_q) begin
                res_ovf_q <= res_ovf_q | DSP_CARRYOUT;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        res_ovf_q <= 1'b0;
                        if (CMD_LEN == LEN_ZERO) begin
                            state_q     <= ST_DONE;
                            res_valid_q <= 1'b1;
                            res_data_q  <= 48'd0;
                        end else begin
                            state_q  <= ST_RUN;
                            remain_q <= CMD_LEN;
                            first_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (s_fire_s) begin
                        remain_q <= remain_q - LEN_ONE;
                        first_q  <= 1'b0;
                        if (last_pair_s) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (t3_vld_q && t3_last_q) begin
                        state_q     <= ST_DONE;
                        res_valid_q <= 1'b1;
                        res_data_q  <= DSP_P;
                    end
                end
                ST_DONE: begin
                    if (RES_READY) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // First pair of a job starts from Z=0, later pairs accumulate onto P.
    always_comb begin
        opmode_s = 8'h00;
        if (t1_vld_q) begin
            if (t1_first_q) begin
                opmode_s = 8'h01;
            end else begin
                opmode_s = 8'h09;
            end
        end else begin
            opmode_s = 8'h00;
        end
    end

    assign CMD_READY     = (state_q == ST_IDLE);
    assign S_READY       = (state_q == ST_RUN) && (remain_q != LEN_ZERO);
    assign RES_VALID     = res_valid_q;
    assign RES_DATA      = res_data_q;
    assign RES_OVF       = res_ovf_q;

    assign DSP_A         = S_A;
    assign DSP_B         = S_B;
    assign DSP_D         = 18'd0;
    assign DSP_C         = 48'd0;
    assign DSP_CARRYIN   = 1'b0;
    assign DSP_OPMODE    = opmode_s;
    assign DSP_CEA       = s_fire_s;
    assign DSP_CEB       = s_fire_s;
    assign DSP_CEM       = t1_vld_q && !abort_s;
    assign DSP_CEOPMODE  = t1_vld_q && !abort_s;
    assign DSP_CEP       = t2_vld_q && !abort_s;
    assign DSP_CECARRYIN = t2_vld_q && !abort_s;
    assign DSP_RST       = RST || abort_s;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: behavioural DSP48A1 slice, randomized jobs,
// reference dot products computed with plain 64-bit arithmetic.
module tb_dsp_mac_sequencer;

    localparam int LEN_W = 16;

    logic             CLK = 1'b0;
    logic             RST;
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [LEN_W-1:0] CMD_LEN;
    logic             ABORT;
    logic             S_VALID;
    logic             S_READY;
    logic [17:0]      S_A;
    logic [17:0]      S_B;
    logic             RES_VALID;
    logic             RES_READY;
    logic [47:0]      RES_DATA;
    logic             RES_OVF;
    logic [17:0]      DSP_A;
    logic [17:0]      DSP_B;
    logic [17:0]      DSP_D;
    logic [47:0]      DSP_C;
    logic             DSP_CARRYIN;
    logic [7:0]       DSP_OPMODE;
    logic             DSP_CEA;
    logic             DSP_CEB;
    logic             DSP_CEM;
    logic             DSP_CEP;
    logic             DSP_CECARRYIN;
    logic             DSP_CEOPMODE;
    logic             DSP_RST;
    logic [47:0]      DSP_P;
    logic             DSP_CARRYOUT;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    dsp_mac_sequencer #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_LEN(CMD_LEN),
        .ABORT(ABORT),
        .S_VALID(S_VALID), .S_READY(S_READY), .S_A(S_A), .S_B(S_B),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA), .RES_OVF(RES_OVF),
        .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_C(DSP_C), .DSP_CARRYIN(DSP_CARRYIN),
        .DSP_OPMODE(DSP_OPMODE),
        .DSP_CEA(DSP_CEA), .DSP_CEB(DSP_CEB), .DSP_CEM(DSP_CEM), .DSP_CEP(DSP_CEP),
        .DSP_CECARRYIN(DSP_CECARRYIN), .DSP_CEOPMODE(DSP_CEOPMODE), .DSP_RST(DSP_RST),
        .DSP_P(DSP_P), .DSP_CARRYOUT(DSP_CARRYOUT)
    );

    // Behavioural slice: A1/B1, M, OPMODE, P and CARRYOUT registers, X/Z muxes, 48-bit post-adder.
    logic [17:0] a1_q, b1_q;
    logic [35:0] m_q;
    logic [7:0]  op_q;
    logic [47:0] p_q;
    logic        co_q;
    logic [48:0] post_s;

    always_comb begin
        post_s = ((op_q[1:0] == 2'b01) ? {13'd0, m_q} : 49'd0)
               + ((op_q[3:2] == 2'b10) ? {1'b0, p_q} : 49'd0);
    end

    always @(posedge CLK) begin
        if (DSP_RST) begin
            a1_q <= 18'd0; b1_q <= 18'd0; m_q <= 36'd0;
            op_q <= 8'd0;  p_q  <= 48'd0; co_q <= 1'b0;
        end else begin
            if (DSP_CEA)       a1_q <= DSP_A;
            if (DSP_CEB)       b1_q <= DSP_B;
            if (DSP_CEM)       m_q  <= 36'(a1_q) * 36'(b1_q);
            if (DSP_CEOPMODE)  op_q <= DSP_OPMODE;
            if (DSP_CEP)       p_q  <= post_s[47:0];
            if (DSP_CECARRYIN) co_q <= post_s[48];
        end
    end

    assign DSP_P        = p_q;
    assign DSP_CARRYOUT = co_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Control-timing monitor: CE/OPMODE must follow the accept history by 1 and 2 cycles.
    bit mon_en = 1'b0;
    bit ab, f0, h1, h2, h1_first, first_pend;

    always @(negedge CLK) begin
        #2;
        if (mon_en) begin
            ab = ABORT && !CMD_READY;
            f0 = S_VALID && S_READY && !ab;
            if (CMD_VALID && CMD_READY) first_pend = 1'b1;
            chk("cea",       64'(DSP_CEA),       64'(f0));
            chk("ceb",       64'(DSP_CEB),       64'(f0));
            chk("cem",       64'(DSP_CEM),       64'(h1 && !ab));
            chk("ceopmode",  64'(DSP_CEOPMODE),  64'(h1 && !ab));
            chk("cep",       64'(DSP_CEP),       64'(h2 && !ab));
            chk("cecarryin", 64'(DSP_CECARRYIN), 64'(h2 && !ab));
            chk("dsp_rst",   64'(DSP_RST),       64'(ab));
            if (!ab) chk("opmode", 64'(DSP_OPMODE), h1 ? (h1_first ? 64'h01 : 64'h09) : 64'h00);
            if (ab) begin
                h1 = 1'b0; h2 = 1'b0; first_pend = 1'b0;
            end else begin
                h2 = h1;
                h1 = f0;
                h1_first = f0 && first_pend;
                if (f0) first_pend = 1'b0;
            end
        end
    end

    logic [17:0] qa[$];
    logic [17:0] qb[$];

    task automatic run_job(input int len, input int gap_pct, input int fixed_gap,
                           input int hold, input int abort_after);
        longint unsigned tsum;
        logic [47:0] exp_data;
        logic        exp_ovf;
        int idx, pause, budget, last_cyc;
        bit got;
        tsum = 0;
        for (int i = 0; i < len; i++) tsum += 64'(qa[i]) * 64'(qb[i]);
        exp_data = tsum[47:0];
        exp_ovf  = (tsum >> 48) != 0;

        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_LEN   = LEN_W'(len);
        #1;
        chk("cmd_ready", 64'(CMD_READY), 64'(1'b1));
        last_cyc = cyc;
        @(negedge CLK);
        CMD_VALID = 1'b0;

        idx = 0; pause = 0; budget = 200 + len * 4;
        while (idx < len && budget > 0) begin
            if (abort_after >= 0 && idx == abort_after) begin
                S_VALID = 1'b1;
                ABORT   = 1'b1;
                #1;
                chk("abort_rst", 64'(DSP_RST), 64'(1'b1));
                chk("abort_cea", 64'(DSP_CEA), 64'(1'b0));
                @(negedge CLK);
                ABORT = 1'b0; S_VALID = 1'b0;
                #1;
                chk("abort_idle", 64'(CMD_READY), 64'(1'b1));
                for (int i = 0; i < 8; i++) begin
                    chk("abort_novalid", 64'(RES_VALID), 64'(1'b0));
                    @(negedge CLK);
                end
                return;
            end
            if (fixed_gap >= 0) begin
                S_VALID = (pause == 0);
            end else begin
                S_VALID = ($urandom_range(0, 99) >= gap_pct);
            end
            S_A = S_VALID ? qa[idx] : 18'($urandom_range(0, 262143));
            S_B = S_VALID ? qb[idx] : 18'($urandom_range(0, 262143));
            #1;
            if (S_VALID && S_READY) begin
                idx++;
                last_cyc = cyc;
                pause = (fixed_gap > 0) ? fixed_gap : 0;
            end else if (pause > 0) begin
                pause--;
            end
            @(negedge CLK);
            budget--;
        end
        S_VALID = 1'b0;
        if (idx < len) chk("feed_timeout", 64'(idx), 64'(len));
        #1;
        chk("s_ready_end", 64'(S_READY), 64'(1'b0));

        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (RES_VALID) got = 1'b1;
            else @(negedge CLK);
        end
        chk("res_valid_seen", 64'(got), 64'(1'b1));
        chk("latency", 64'(cyc - last_cyc), (len == 0) ? 64'd1 : 64'd4);
        chk("res_data", 64'(RES_DATA), 64'(exp_data));
        chk("res_ovf",  64'(RES_OVF),  64'(exp_ovf));
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            chk("hold_valid", 64'(RES_VALID), 64'(1'b1));
            chk("hold_data",  64'(RES_DATA),  64'(exp_data));
            chk("hold_busy",  64'(CMD_READY), 64'(1'b0));
        end
        RES_READY = 1'b1;
        @(negedge CLK);
        RES_READY = 1'b0;
        #1;
        chk("accept_clr", 64'(RES_VALID), 64'(1'b0));
        chk("accept_idle", 64'(CMD_READY), 64'(1'b1));
    endtask

    initial begin
        RST = 1'b1; CMD_VALID = 1'b0; CMD_LEN = '0; ABORT = 1'b0;
        S_VALID = 1'b0; S_A = 18'd0; S_B = 18'd0; RES_READY = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_cmd_ready", 64'(CMD_READY), 64'(1'b1));
        chk("rst_res_valid", 64'(RES_VALID), 64'(1'b0));
        chk("rst_s_ready",   64'(S_READY),   64'(1'b0));
        chk("rst_dsp_rst",   64'(DSP_RST),   64'(1'b1));
        chk("rst_res_data",  64'(RES_DATA),  64'd0);
        chk("rst_res_ovf",   64'(RES_OVF),   64'(1'b0));
        chk("rst_opmode",    64'(DSP_OPMODE), 64'd0);
        chk("rst_ces", 64'({DSP_CEA, DSP_CEB, DSP_CEM, DSP_CEP, DSP_CECARRYIN, DSP_CEOPMODE}), 64'd0);
        chk("rst_ties", 64'(DSP_D) | 64'(DSP_C[47:0]) | 64'(DSP_CARRYIN), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        mon_en = 1'b1;

        qa = '{18'd2, 18'd4, 18'd6}; qb = '{18'd3, 18'd5, 18'd7};
        run_job(3, 0, -1, 0, -1);

        qa = '{18'd1000, 18'd3}; qb = '{18'd1000, 18'd3};
        run_job(2, 0, 5, 0, -1);

        qa.delete(); qb.delete();
        run_job(0, 0, -1, 10, -1);

        qa.delete(); qb.delete();
        for (int i = 0; i < 5; i++) begin
            qa.push_back(18'($urandom_range(0, 262143)));
            qb.push_back(18'($urandom_range(0, 262143)));
        end
        run_job(5, 0, -1, 0, 2);
        qa = '{18'd9}; qb = '{18'd9};
        run_job(1, 0, -1, 0, -1);

        for (int j = 0; j < 6; j++) begin
            int n;
            n = $urandom_range(1, 24);
            qa.delete(); qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(18'($urandom_range(0, 262143)));
                qb.push_back(18'($urandom_range(0, 262143)));
            end
            run_job(n, $urandom_range(0, 60), -1, $urandom_range(0, 3), -1);
        end

        qa.delete(); qb.delete();
        for (int i = 0; i < 65535; i++) begin
            qa.push_back(18'h3FFFF);
            qb.push_back(18'h3FFFF);
        end
        run_job(65535, 0, -1, 0, -1);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
